// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target endpoint: FSM state encoding,
// default bus address and R/W bit encoding.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    RX        = 3'd3,
    RX_ACK    = 3'd4,
    TX        = 3'd5,
    TX_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } i2c_state_t;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h50;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // The all-zero address is reserved and is never acknowledged.
  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [6:0] slave_addr);
    return (slave_addr != '0) && (addr_byte[7:1] == slave_addr);
  endfunction

endpackage

// File: rtl/i2c_slave_fsm_if.sv
// Bus and register-file port bundle of the I2C target endpoint.
interface i2c_slave_fsm_if;
  import i2c_pkg::*;

  logic       scl;
  logic       sda_in;
  logic       sda_oe;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  i2c_state_t state;
  logic       busy;

  modport slave (
    input  scl, sda_in, rd_data,
    output sda_oe, wr_en, wr_addr, wr_data, rd_addr, state, busy
  );

  modport master (
    output scl, sda_in, rd_data,
    input  sda_oe, wr_en, wr_addr, wr_data, rd_addr, state, busy
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises bus SCL/SDA into scl_clk and produces registered SCL edge,
// START and STOP pulses; all outputs share one 3-cycle latency.
module i2c_bus_sync (
  input  logic scl_clk,
  input  logic reset,
  input  logic scl,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic scl_m, scl_y, scl_p;
  logic sda_m, sda_y, sda_p;

  // Synchroniser stages reset to the idle-bus level so reset release is quiet.
  always_ff @(posedge scl_clk or posedge reset) begin
    if (reset) begin
      scl_m     <= 1'b1;
      scl_y     <= 1'b1;
      scl_p     <= 1'b1;
      sda_m     <= 1'b1;
      sda_y     <= 1'b1;
      sda_p     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_m     <= scl;
      scl_y     <= scl_m;
      scl_p     <= scl_y;
      sda_m     <= sda_in;
      sda_y     <= sda_m;
      sda_p     <= sda_y;
      scl_rise  <= scl_y & ~scl_p;
      scl_fall  <= ~scl_y & scl_p;
      start_det <= scl_y & scl_p & sda_p & ~sda_y;
      stop_det  <= scl_y & scl_p & ~sda_p & sda_y;
    end
  end

  // sda_p holds the same sample instant that the edge pulses were computed from.
  assign sda_s = sda_p;

endmodule

// File: rtl/i2c_slave_fsm.sv
// I2C target: address, register pointer, then data bytes into a register port.
// Read service (TX/TX_ACK) is built only when I2C_SLAVE_READ_EN is defined.
module i2c_slave_fsm
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = I2C_DEFAULT_ADDR
) (
  input  logic         scl_clk,
  input  logic         reset,
  i2c_slave_fsm_if.slave bus
);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_bus_sync u_sync (
    .scl_clk   (scl_clk),
    .reset     (reset),
    .scl       (bus.scl),
    .sda_in    (bus.sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_t state;
  logic       sda_oe;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] ptr;
  logic [7:0] shift;
  logic [3:0] bit_cnt;
  logic       ptr_phase;
  logic [7:0] rx_byte;
  logic       rw_ok;

  assign rx_byte = {shift[6:0], sda_s};

`ifdef I2C_SLAVE_READ_EN
  logic rw;
  logic tx_acked;
  assign rw_ok = 1'b1;
`else
  logic rd_data_unused;
  assign rw_ok          = (rx_byte[0] == RW_WRITE);
  assign rd_data_unused = ^bus.rd_data;
`endif

  always_ff @(posedge scl_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sda_oe    <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      ptr       <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
      ptr_phase <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
      rw        <= RW_WRITE;
      tx_acked  <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: if (scl_rise) begin
            shift <= rx_byte;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              state   <= (addr_match(rx_byte, SLAVE_ADDR) && rw_ok) ? ADDR_ACK : WAIT_STOP;
`ifdef I2C_SLAVE_READ_EN
              rw      <= rx_byte[0];
`endif
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          // sda_oe doubles as the phase flag: first fall asserts ACK, second ends it.
          ADDR_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
`ifdef I2C_SLAVE_READ_EN
              if (rw == RW_READ) begin
                state   <= TX;
                shift   <= {bus.rd_data[6:0], 1'b0};
                sda_oe  <= ~bus.rd_data[7];
                bit_cnt <= 4'd1;
              end else
`endif
              begin
                state     <= RX;
                ptr_phase <= 1'b1;
              end
            end
          end
          RX: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state   <= RX_ACK;
              sda_oe  <= 1'b1;
              bit_cnt <= '0;
              if (ptr_phase) begin
                ptr       <= shift;
                ptr_phase <= 1'b0;
              end else begin
                wr_en   <= 1'b1;
                wr_addr <= ptr;
                wr_data <= shift;
                ptr     <= ptr + 8'd1;
              end
            end
          end
          RX_ACK: if (scl_fall) begin
            sda_oe <= 1'b0;
            state  <= RX;
          end
`ifdef I2C_SLAVE_READ_EN
          // Bit n is already on the bus after the fall that counted it; the ninth fall releases SDA.
          TX: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe   <= 1'b0;
              state    <= TX_ACK;
              bit_cnt  <= '0;
              tx_acked <= 1'b0;
            end else begin
              sda_oe  <= ~shift[7];
              shift   <= {shift[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                ptr      <= ptr + 8'd1;
                tx_acked <= 1'b1;
              end else begin
                state <= WAIT_STOP;
              end
            end else if (scl_fall && tx_acked) begin
              state   <= TX;
              shift   <= {bus.rd_data[6:0], 1'b0};
              sda_oe  <= ~bus.rd_data[7];
              bit_cnt <= 4'd1;
            end
          end
`endif
          WAIT_STOP: sda_oe <= 1'b0;
          default: begin
            sda_oe <= 1'b0;
            state  <= WAIT_STOP;
          end
        endcase
      end
    end
  end

  assign bus.state   = state;
  assign bus.busy    = (state != IDLE);
  assign bus.sda_oe  = sda_oe;
  assign bus.wr_en   = wr_en;
  assign bus.wr_addr = wr_addr;
  assign bus.wr_data = wr_data;
  assign bus.rd_addr = ptr;

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Bench for i2c_slave_fsm: bit-banged I2C master, open-drain bus model and a
// transaction-level reference model of pointer, writes and read data.
`timescale 1ns/1ps
module tb_i2c_slave_fsm;

  localparam logic [6:0] SLV = 7'h50;
  localparam int         Q   = 5;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd7;
`ifdef I2C_SLAVE_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic scl_clk = 1'b0;
  logic reset;
  logic m_scl, m_sda;

  always #5 scl_clk = ~scl_clk;

  i2c_slave_fsm_if bus ();

  assign bus.scl     = m_scl;
  assign bus.sda_in  = m_sda & ~bus.sda_oe;
  assign bus.rd_data = bus.rd_addr ^ 8'hFF;

  i2c_slave_fsm #(.SLAVE_ADDR(SLV)) dut (
    .scl_clk (scl_clk),
    .reset   (reset),
    .bus     (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] wr_q[$];
  logic        wr_prev = 1'b0;
  int unsigned wr_double = 0;
  int unsigned busy_bad = 0;
  bit          oe_seen = 1'b0;
  logic [7:0]  model_ptr;
  logic [7:0]  tx_buf [8];

  always @(negedge scl_clk) begin
    if (!reset) begin
      if (bus.wr_en) wr_q.push_back({bus.wr_addr, bus.wr_data});
      if (bus.wr_en && wr_prev) wr_double++;
      wr_prev = bus.wr_en;
      if (bus.sda_oe) oe_seen = 1'b1;
      if (bus.busy !== (bus.state != ST_IDLE)) busy_bad++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic qwait();
    repeat (Q) @(negedge scl_clk);
  endtask

  task automatic i2c_start();
    if (!m_scl) begin
      m_sda = 1'b1; qwait();
      m_scl = 1'b1; qwait();
    end else begin
      m_sda = 1'b1; qwait();
    end
    m_sda = 1'b0; qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; qwait();
    m_scl = 1'b1; qwait();
    m_sda = 1'b1; qwait(); qwait();
  endtask

  task automatic send_bit(input logic b, output logic line);
    m_sda = b;    qwait();
    m_scl = 1'b1; qwait();
    line  = bus.sda_in; qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic [7:0] seen, output logic ack);
    logic line;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i], line);
      seen[i] = line;
    end
    send_bit(1'b1, line);
    ack = ~line;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] got);
    logic line;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, line);
      got[i] = line;
    end
    send_bit(nack, line);
  endtask

  // tx_buf[0] is the pointer byte, tx_buf[1..n-1] are data bytes.
  task automatic write_xfer(input logic [6:0] a7, input int n, input bit do_stop);
    logic [7:0]  seen;
    logic        ack;
    logic [15:0] exp_w[$];
    bit          exp_ack;
    wr_q.delete();
    oe_seen = 1'b0;
    exp_ack = (a7 == SLV) && (a7 != 7'h00);
    i2c_start();
    write_byte({a7, 1'b0}, seen, ack);
    check_eq("w_addr_line", seen, {a7, 1'b0});
    check_eq("w_addr_ack", ack, exp_ack);
    for (int i = 0; i < n; i++) begin
      write_byte(tx_buf[i], seen, ack);
      check_eq("w_data_line", seen, tx_buf[i]);
      check_eq("w_data_ack", ack, exp_ack);
      if (exp_ack) begin
        if (i == 0) model_ptr = tx_buf[0];
        else begin
          exp_w.push_back({model_ptr, tx_buf[i]});
          model_ptr = model_ptr + 8'd1;
        end
      end
    end
    if (!exp_ack) begin
      check_eq("nomatch_state", bus.state, ST_WAIT);
      check_eq("nomatch_oe", oe_seen, 1'b0);
    end
    if (do_stop) begin
      i2c_stop();
      check_eq("stop_state", bus.state, ST_IDLE);
    end
    check_eq("wr_count", wr_q.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++)
      check_eq("wr_pair", wr_q[i], exp_w[i]);
    check_eq("ptr", bus.rd_addr, model_ptr);
  endtask

  task automatic read_xfer(input logic [6:0] a7, input int n);
    logic [7:0] seen;
    logic       ack;
    bit         exp_ack;
    oe_seen = 1'b0;
    exp_ack = (a7 == SLV) && (a7 != 7'h00) && READ_EN;
    i2c_start();
    write_byte({a7, 1'b1}, seen, ack);
    check_eq("r_addr_ack", ack, exp_ack);
    if (exp_ack) begin
      for (int i = 0; i < n; i++) begin
        read_byte(i == n - 1, seen);
        check_eq("rd_byte", seen, model_ptr ^ 8'hFF);
        if (i != n - 1) model_ptr = model_ptr + 8'd1;
      end
      check_eq("nack_state", bus.state, ST_WAIT);
      check_eq("nack_oe", bus.sda_oe, 1'b0);
    end else begin
      check_eq("r_nack_state", bus.state, ST_WAIT);
      check_eq("r_nack_oe", oe_seen, 1'b0);
    end
    i2c_stop();
    check_eq("r_stop_state", bus.state, ST_IDLE);
    check_eq("r_ptr", bus.rd_addr, model_ptr);
  endtask

  initial begin
    logic [7:0] seen;
    logic       ack, line;
    logic [6:0] a7;
    int         n;
    m_scl = 1'b1;
    m_sda = 1'b1;
    reset = 1'b1;
    model_ptr = 8'h00;
    repeat (3) @(negedge scl_clk);
    check_eq("rst_state", bus.state, ST_IDLE);
    check_eq("rst_oe", bus.sda_oe, 1'b0);
    check_eq("rst_wr_en", bus.wr_en, 1'b0);
    check_eq("rst_wr_addr", bus.wr_addr, 8'h00);
    check_eq("rst_wr_data", bus.wr_data, 8'h00);
    check_eq("rst_rd_addr", bus.rd_addr, 8'h00);
    check_eq("rst_busy", bus.busy, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge scl_clk);

    // single write
    tx_buf[0] = 8'h03; tx_buf[1] = 8'h5A;
    write_xfer(SLV, 2, 1'b1);
    check_eq("w1_ptr_const", bus.rd_addr, 8'h04);

    // burst across pointer wrap
    tx_buf[0] = 8'hFF; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22;
    write_xfer(SLV, 3, 1'b1);
    check_eq("wrap_ptr_const", bus.rd_addr, 8'h01);

    // address mismatch (0xA2)
    tx_buf[0] = 8'h00;
    write_xfer(7'h51, 1, 1'b1);

    // pointer write, repeated START, read two bytes
    tx_buf[0] = 8'h07;
    write_xfer(SLV, 1, 1'b0);
    read_xfer(SLV, 2);
    read_xfer(SLV, 1);

    // reset in the middle of a data byte
    wr_q.delete();
    i2c_start();
    write_byte({SLV, 1'b0}, seen, ack);
    write_byte(8'h20, seen, ack);
    check_eq("rst_mid_ptr_ack", ack, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), line);
    reset = 1'b1;
    #1;
    check_eq("rst_mid_oe", bus.sda_oe, 1'b0);
    check_eq("rst_mid_state", bus.state, ST_IDLE);
    check_eq("rst_mid_wr_en", bus.wr_en, 1'b0);
    repeat (3) @(negedge scl_clk);
    reset = 1'b0;
    model_ptr = 8'h00;
    check_eq("rst_mid_ptr", bus.rd_addr, 8'h00);
    i2c_stop();
    check_eq("rst_mid_no_write", wr_q.size(), 0);
    tx_buf[0] = 8'h30; tx_buf[1] = 8'hC3; tx_buf[2] = 8'h3C;
    write_xfer(SLV, 3, 1'b1);

    // randomized transactions
    for (int t = 0; t < 20; t++) begin
      a7 = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : SLV;
      if (t == 5) a7 = 7'h00;
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
        write_xfer(a7, n, 1'b1);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          tx_buf[0] = 8'($urandom);
          write_xfer(a7, 1, 1'b0);
        end
        read_xfer(a7, $urandom_range(1, 3));
      end
    end

    check_eq("wr_en_width", wr_double, 0);
    check_eq("busy_track", busy_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_fsm.md
# i2c_slave_fsm

I2C target (slave) endpoint that answers the transactions produced by the team's I2C master FSM. Addresses a target address, then a register pointer byte, then data bytes. Synchronises bus SCL/SDA into the local `scl_clk` domain and detects START/STOP. Drives SDA open-drain for ACK and read data, and exposes a simple register-file write/read port to the surrounding design.

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit bus address this target acknowledges.
- `scl_clk`, in, 1: sampling clock; must be ≥ 8× bus SCL frequency.
- `reset`, in, 1: reset reset, asynchronous, active-high; clock scl_clk.
- `scl`, in, 1: bus SCL (asynchronous).
- `sda_in`, in, 1: bus SDA (asynchronous).
- `sda_oe`, out, 1: 1 = pull SDA low; 0 = release. Never drives high.
- `wr_en`, out, 1: one-cycle write strobe.
- `wr_addr`, out, 8: write address, valid with `wr_en`.
- `wr_data`, out, 8: write data, valid with `wr_en`.
- `rd_addr`, out, 8: current register pointer; always equals internal pointer.
- `rd_data`, in, 8: read data for `rd_addr`; must be valid by the cycle after `rd_addr` changes.
- `state`, out, 3: current FSM state.
- `busy`, out, 1: high whenever `state` is not IDLE.

## Operation
- Input path: 2-flop synchroniser on `scl`/`sda_in`; edges detected from synchronised current vs previous values.
- START = SDA falls while SCL high. STOP = SDA rises while SCL high.
- START/STOP take priority over bit processing in the same cycle.
- Any START, including a repeated START, enters ADDR with bit count 0 and `sda_oe`=0.
- Any STOP enters IDLE with `sda_oe`=0.
- Bits are sampled MSB first on the SCL rising-edge detect. `sda_oe` changes only on the SCL falling-edge detect.
- FSM states (3-bit): IDLE=0, ADDR=1, ADDR_ACK=2, RX=3, RX_ACK=4, TX=5, TX_ACK=6, WAIT_STOP=7.
- ADDR: shift 8 bits.
  - Match on upper 7 bits = `SLAVE_ADDR`, and R/W permitted → ADDR_ACK.
  - Otherwise → WAIT_STOP.
  - Address 7'h00 is never acknowledged.
- ADDR_ACK: `sda_oe`=1 from the next SCL fall to the following SCL fall.
  - At release, W → RX (pointer phase).
  - At release, R → TX, with the shift register loaded from `rd_data`.
- RX: 8 bits, then RX_ACK drives ACK for one SCL period.
  - First byte after W loads the pointer.
  - Each later byte pulses `wr_en` for 1 cycle at the SCL fall that begins ACK, with `wr_addr`=pointer and `wr_data`=byte. The pointer then increments.
  - Returns to RX.
- TX: `sda_oe` = ~bit, set at each SCL fall, for 8 bits. SDA is then released and the FSM enters TX_ACK.
- TX_ACK: sample master ACK at SCL rise.
  - ACK (0) → pointer+1; at the next SCL fall, load `rd_data` and go to TX.
  - NACK → WAIT_STOP.
- WAIT_STOP: `sda_oe`=0; ignores bits until START or STOP.
- Pointer arithmetic is 8-bit, wrapping 0xFF→0x00. The pointer persists across transactions.

## Timing
- Reset values:
  - `state`=IDLE, `sda_oe`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `rd_addr`=0, `busy`=0.
  - Pointer, shift register and bit count = 0.
- Input-to-detect latency: 3 `scl_clk` cycles (2 sync + 1 edge register).
- `wr_en` is high exactly 1 cycle per received data byte.
- Reset mid-transfer immediately releases SDA and returns to IDLE. No partial write is issued.

## Configuration
- `I2C_SLAVE_READ_EN` defined: read transactions (R/W=1) are acknowledged and served via TX/TX_ACK.
- `I2C_SLAVE_READ_EN` undefined:
  - Address with R/W=1 is NACKed and goes to WAIT_STOP.
  - TX/TX_ACK logic is omitted.
  - `rd_addr` still tracks the pointer; `rd_data` is unused.

## Structure
- Shared package `i2c_pkg` holds:
  - the 3-bit state constants listed above;
  - default `SLAVE_ADDR`;
  - the R/W bit encoding (W=0, R=1).
- Sub-module `i2c_bus_sync` contains the synchroniser, the edge registers and START/STOP detection. Its outputs are `scl_rise`, `scl_fall`, `sda_s`, `start_det` and `stop_det`.

## Test plan
- Write: START, 0xA0, 0x03, 0x5A, STOP → 3 ACKs; single `wr_en` with `wr_addr`=0x03, `wr_data`=0x5A; pointer ends at 0x04.
- Burst with wrap: START, 0xA0, 0xFF, 0x11, 0x22, STOP → writes (0xFF,0x11) then (0x00,0x22); pointer ends at 0x01.
- Mismatch: START, 0xA2, 0x00, STOP → `sda_oe` never asserted, no `wr_en`, `state` WAIT_STOP until STOP.
- Read (macro on), with `rd_data` = `rd_addr`^0xFF:
  - Stimulus: START, 0xA0, 0x07, repeated START, 0xA1, master ACK, NACK, STOP.
  - Response: bytes 0xF8 then 0xF7 on SDA; SDA released after NACK.
- Macro off: START, 0xA1 → NACK, WAIT_STOP, no SDA drive.
- Reset asserted during RX bit 4 → `sda_oe`=0, `state`=IDLE, no `wr_en`; a following full write completes normally.
